// File: rtl/stream_wb_burst_writer_pkg.sv
// Shared definitions for the stream-to-Wishbone burst writer.
//   CTI_*   : Wishbone cycle-type encodings driven on wbm_cti_o
//   state_t : burst engine states
package stream_wb_burst_writer_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO.
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_push, i_data : write request and word (ignored while full)
//   i_pop          : consume head word (ignored while empty)
//   o_data         : head word, valid whenever o_empty is low
//   o_level        : occupancy 0..DEPTH
//   o_full         : registered full flag
//   o_empty        : level is zero
module sync_fifo_fwft #(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 32
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic [AW:0]      w_level_next;
  logic             r_full;
  logic             w_push;
  logic             w_pop;

  assign w_push = i_push && !r_full;
  assign w_pop  = i_pop && (r_level != '0);

  always_comb begin
    w_level_next = r_level;
    case ({w_push, w_pop})
      2'b10:   w_level_next = r_level + (AW+1)'(1);
      2'b01:   w_level_next = r_level - (AW+1)'(1);
      default: w_level_next = r_level;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_full   <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_level <= w_level_next;
      r_full  <= (w_level_next == (AW+1)'(DEPTH));
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_level = r_level;
  assign o_full  = r_full;
  assign o_empty = (r_level == '0);

endmodule

// File: rtl/stream_wb_burst_writer.sv
// Buffers a 32-bit word stream and writes it into a frame buffer as
// Wishbone incrementing bursts; the write pointer returns to BASE_ADDR
// after each last-flagged word or after FRAME_WORDS words.
//   wb_clk_i, wb_rst_n_i : clock, synchronous active-low reset
//   s_*                  : input stream (valid/ready, last marks end of frame)
//   wbm_*                : Wishbone master write port
//   clr_status_i         : clears the sticky overflow flag
//   frame_done_o         : one-cycle pulse after a last-flagged word is acked
//   overflow_o           : sticky, a word was presented while not ready
//   fifo_level_o         : FIFO occupancy
module stream_wb_burst_writer
  import stream_wb_burst_writer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned FRAME_WORDS = 81920,
  parameter int unsigned BURST_LEN   = 8,
  parameter int unsigned FIFO_DEPTH  = 32
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_n_i,
  input  logic [31:0]                   s_data_i,
  input  logic                          s_last_i,
  input  logic                          s_valid_i,
  output logic                          s_ready_o,
  output logic [31:0]                   wbm_adr_o,
  output logic [31:0]                   wbm_dat_o,
  output logic [3:0]                    wbm_sel_o,
  output logic [2:0]                    wbm_cti_o,
  output logic                          wbm_we_o,
  output logic                          wbm_cyc_o,
  output logic                          wbm_stb_o,
  input  logic                          wbm_ack_i,
  input  logic                          clr_status_i,
  output logic                          frame_done_o,
  output logic                          overflow_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned IW = $clog2(FRAME_WORDS) + 1;
  localparam int unsigned BW = $clog2(BURST_LEN) + 1;

  state_t          r_state;
  state_t          w_state_next;
  logic            r_cyc;
  logic            r_ready_en;
  logic            r_frame_done;
  logic            r_overflow;
  logic [BW-1:0]   r_beat;
  logic [31:0]     r_wr_ptr;
  logic [IW-1:0]   r_word_idx;
  logic [LW-1:0]   r_last_pending;

  logic [32:0]     w_head;
  logic [LW-1:0]   w_level;
  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic            w_head_last;
  logic            w_trigger;
  logic            w_end_beat;
  logic            w_underrun;

  sync_fifo_fwft #(
    .WIDTH(33),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (wb_clk_i),
    .i_rst_n (wb_rst_n_i),
    .i_push  (w_push),
    .i_data  ({s_last_i, s_data_i}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_level (w_level),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Ready is held low through the first cycle after reset and otherwise
  // follows the registered full flag, so a pop never frees a slot for a
  // push in the same cycle.
  assign s_ready_o   = r_ready_en && !w_full;
  assign w_push      = s_valid_i && s_ready_o;
  assign w_pop       = r_cyc && wbm_ack_i;
  assign w_head_last = w_head[32];
  assign w_trigger   = (w_level >= LW'(BURST_LEN)) || (r_last_pending != '0);
  assign w_end_beat  = (wbm_cti_o != CTI_INCR);
  assign w_underrun  = (w_level == LW'(1)) && !w_push;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_trigger) w_state_next = BURST;
      BURST:   if (w_pop && (w_end_beat || w_underrun)) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      r_state        <= IDLE;
      r_cyc          <= 1'b0;
      r_ready_en     <= 1'b0;
      r_frame_done   <= 1'b0;
      r_overflow     <= 1'b0;
      r_beat         <= '0;
      r_wr_ptr       <= BASE_ADDR;
      r_word_idx     <= '0;
      r_last_pending <= '0;
    end else begin
      r_state    <= w_state_next;
      r_ready_en <= 1'b1;
      // cyc rises one edge after entering BURST and falls on the edge that
      // leaves it, which guarantees an idle cycle between bursts.
      r_cyc        <= (r_state == BURST) && (w_state_next == BURST);
      r_frame_done <= w_pop && w_head_last;

      if (s_valid_i && !s_ready_o) r_overflow <= 1'b1;
      else if (clr_status_i)       r_overflow <= 1'b0;

      case ({w_push && s_last_i, w_pop && w_head_last})
        2'b10:   r_last_pending <= r_last_pending + LW'(1);
        2'b01:   r_last_pending <= r_last_pending - LW'(1);
        default: r_last_pending <= r_last_pending;
      endcase

      if (r_state == IDLE) r_beat <= '0;
      else if (w_pop)      r_beat <= r_beat + BW'(1);

      if (w_pop) begin
        if (w_head_last || (r_word_idx == IW'(FRAME_WORDS - 1))) begin
          r_word_idx <= '0;
          r_wr_ptr   <= BASE_ADDR;
        end else begin
          r_word_idx <= r_word_idx + IW'(1);
          r_wr_ptr   <= r_wr_ptr + 32'd4;
        end
      end
    end
  end

  always_comb begin
    wbm_cyc_o = r_cyc;
    wbm_stb_o = r_cyc;
    wbm_we_o  = r_cyc;
    wbm_sel_o = 4'hF;
    wbm_adr_o = r_wr_ptr;
    wbm_dat_o = w_head[31:0];
    wbm_cti_o = CTI_CLASSIC;
    if (r_cyc && !w_empty) begin
      if (w_head_last && (r_beat == '0))
        wbm_cti_o = CTI_CLASSIC;
      else if (w_head_last || (r_beat == BW'(BURST_LEN - 1)))
        wbm_cti_o = CTI_END;
      else
        wbm_cti_o = CTI_INCR;
    end
  end

  assign frame_done_o = r_frame_done;
  assign overflow_o   = r_overflow;
  assign fifo_level_o = w_level;

endmodule
